// File: rtl/rtable_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtable_pkg
// Description : Shared constants for the route-table lookup arbiter
//               (sizes, direction codes, input-port indices).
// Revision    : 1.0 - initial release
// ============================================================================
package rtable_pkg;

    localparam int NPORTS = 5;
    localparam int ID_W   = 8;
    localparam int DIR_W  = 3;
    localparam int SRC_W  = $clog2(NPORTS);

    localparam logic [DIR_W-1:0] DIR_LOCAL = 3'd0;
    localparam logic [DIR_W-1:0] DIR_NORTH = 3'd1;
    localparam logic [DIR_W-1:0] DIR_EAST  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_SOUTH = 3'd3;
    localparam logic [DIR_W-1:0] DIR_WEST  = 3'd4;

    localparam logic [SRC_W-1:0] P_NORTH = 3'd0;
    localparam logic [SRC_W-1:0] P_EAST  = 3'd1;
    localparam logic [SRC_W-1:0] P_SOUTH = 3'd2;
    localparam logic [SRC_W-1:0] P_WEST  = 3'd3;
    localparam logic [SRC_W-1:0] P_LOCAL = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rtable_lookup_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : rtable_lookup_arb_if
// Description : Request/response bundle between the input-port buffers
//               (master) and the lookup arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rtable_lookup_arb_if
    import rtable_pkg::*;
#(
    parameter int NPORTS = rtable_pkg::NPORTS,
    parameter int ID_W   = rtable_pkg::ID_W,
    parameter int DIR_W  = rtable_pkg::DIR_W,
    parameter int SRC_W  = rtable_pkg::SRC_W
);
    logic [NPORTS-1:0]      req_valid;
    logic [NPORTS*ID_W-1:0] req_dest;
    logic [NPORTS-1:0]      req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [SRC_W-1:0]       resp_src;
    logic [DIR_W-1:0]       resp_dir;
    logic                   resp_err;

    modport master (
        output req_valid, req_dest, resp_ready,
        input  req_ready, resp_valid, resp_src, resp_dir, resp_err
    );

    modport slave (
        input  req_valid, req_dest, resp_ready,
        output req_ready, resp_valid, resp_src, resp_dir, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/rtable_lookup_arb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; priority starts just after
//               the last granted index held in ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rtable_pkg::*;
#(
    parameter int NPORTS = rtable_pkg::NPORTS,
    parameter int IDX_W  = rtable_pkg::SRC_W
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              en,
    output logic [NPORTS-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);
    int               w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        // ptr < NPORTS and k <= NPORTS, so one subtraction is enough to wrap
        for (int k = 1; k <= NPORTS; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= NPORTS) begin
                w_sum = w_sum - NPORTS;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (en && !any && req[w_idx]) begin
                any       = 1'b1;
                grant_idx = w_idx;
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/rtable_lookup_arb.sv
`default_nettype none
// ============================================================================
// Module      : rtable_lookup_arb
// Description : Shares one registered route-table lookup among the input
//               ports; two-stage pipeline with a backpressured response.
// Revision    : 1.0 - initial release
// ============================================================================
module rtable_lookup_arb
    import rtable_pkg::*;
#(
    parameter int NPORTS = rtable_pkg::NPORTS,
    parameter int ID_W   = rtable_pkg::ID_W,
    parameter int DIR_W  = rtable_pkg::DIR_W,
    parameter int SRC_W  = rtable_pkg::SRC_W
) (
    input  logic              clk,
    input  logic              rst,
    rtable_lookup_arb_if.slave bus,
    output logic [ID_W-1:0]   rt_dest_id,
    input  logic [DIR_W-1:0]  rt_switch_port
);
    logic              s1_v_q, s1_v_d;
    logic [SRC_W-1:0]  s1_src_q, s1_src_d;
    logic [ID_W-1:0]   s1_dest_q, s1_dest_d;
    logic              resp_valid_q, resp_valid_d;
    logic [SRC_W-1:0]  resp_src_q, resp_src_d;
    logic [DIR_W-1:0]  resp_dir_q, resp_dir_d;
    logic              resp_err_q, resp_err_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;

    logic              w_adv1, w_adv2, w_en, w_any;
    logic [NPORTS-1:0] w_grant;
    logic [SRC_W-1:0]  w_grant_idx;
    logic [ID_W-1:0]   w_grant_dest;

    assign w_adv2 = !resp_valid_q || bus.resp_ready;
    assign w_adv1 = !s1_v_q || w_adv2;
    assign w_en   = w_adv1 && !rst;

    rr_arbiter #(
        .NPORTS (NPORTS),
        .IDX_W  (SRC_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .en        (w_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    always_comb begin
        w_grant_dest = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_grant[i]) begin
                w_grant_dest = bus.req_dest[i*ID_W +: ID_W];
            end
        end
    end

    // While stalled the table re-samples the in-flight ID so its output stays valid
    always_comb begin
        rt_dest_id = '0;
        if (!rst) begin
            if (!w_adv1) begin
                rt_dest_id = s1_dest_q;
            end else if (w_any) begin
                rt_dest_id = w_grant_dest;
            end
        end
    end

    always_comb begin
        s1_v_d       = s1_v_q;
        s1_src_d     = s1_src_q;
        s1_dest_d    = s1_dest_q;
        resp_valid_d = resp_valid_q;
        resp_src_d   = resp_src_q;
        resp_dir_d   = resp_dir_q;
        resp_err_d   = resp_err_q;
        ptr_d        = ptr_q;

        if (w_adv1) begin
            s1_v_d    = w_any;
            s1_src_d  = w_any ? w_grant_idx  : '0;
            s1_dest_d = w_any ? w_grant_dest : '0;
        end
        if (w_any) begin
            ptr_d = w_grant_idx;
        end
        if (w_adv2) begin
            resp_valid_d = s1_v_q;
            resp_src_d   = s1_src_q;
            resp_dir_d   = rt_switch_port;
            resp_err_d   = (rt_switch_port > DIR_W'(DIR_WEST));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            s1_src_q     <= '0;
            s1_dest_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_src_q   <= '0;
            resp_dir_q   <= '0;
            resp_err_q   <= 1'b0;
            ptr_q        <= SRC_W'(NPORTS - 1);
        end else begin
            s1_v_q       <= s1_v_d;
            s1_src_q     <= s1_src_d;
            s1_dest_q    <= s1_dest_d;
            resp_valid_q <= resp_valid_d;
            resp_src_q   <= resp_src_d;
            resp_dir_q   <= resp_dir_d;
            resp_err_q   <= resp_err_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_src   = resp_src_q;
    assign bus.resp_dir   = resp_dir_q;
    assign bus.resp_err   = resp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_rtable_lookup_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtable_lookup_arb
// Description : Bench for rtable_lookup_arb with an XY route table for node
//               (7,8) on a 16x16 mesh and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtable_lookup_arb;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rt_dest_id;
    logic [2:0] rt_switch_port;
    logic [2:0] rt_q;
    logic       stub_arm;

    rtable_lookup_arb_if bus_if ();

    rtable_lookup_arb dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .rt_dest_id     (rt_dest_id),
        .rt_switch_port (rt_switch_port)
    );

    always #5 clk = ~clk;

    // Dest ID is {y,x}; XY routing resolves X first, node sits at x=7, y=8
    function automatic logic [2:0] route(input logic [7:0] d);
        if (d[3:0] > 4'd7) return 3'd2;
        if (d[3:0] < 4'd7) return 3'd4;
        if (d[7:4] > 4'd8) return 3'd1;
        if (d[7:4] < 4'd8) return 3'd3;
        return 3'd0;
    endfunction

    always_ff @(posedge clk) rt_q <= stub_arm ? 3'b111 : route(rt_dest_id);
    assign rt_switch_port = rt_q;

    typedef struct { int src; logic [7:0] dest; logic [2:0] dir; int cyc; } item_t;
    typedef struct { int src; logic [2:0] dir; logic err; } resp_t;

    item_t      q[$];
    resp_t      got[$];
    int         gq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mptr = N - 1;
    logic [N-1:0] want = '0;
    logic [7:0] hold [N];

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive, compare against the model, then retire/accept in the model
    task automatic step();
        int          g;
        logic        allowed;
        logic        exp_rv;
        logic [N-1:0] exp_rdy;
        logic [7:0]  exp_rt;
        item_t       it;
        resp_t       r;
        bus_if.req_valid = want;
        for (int i = 0; i < N; i++) bus_if.req_dest[i*8 +: 8] = hold[i];
        #1;
        allowed = (q.size() < 2) || bus_if.resp_ready;
        g       = allowed ? rr_pick(want, mptr) : -1;
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        exp_rt  = (g >= 0) ? hold[g] : (!allowed ? q[$].dest : 8'h00);
        checks++;
        if (bus_if.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus_if.req_ready, exp_rdy);
        end
        checks++;
        if (rt_dest_id !== exp_rt) begin
            errors++;
            $display("FAIL rt_dest_id cyc=%0d got=%h exp=%h", cyc, rt_dest_id, exp_rt);
        end
        exp_rv = (q.size() > 0) && (q[0].cyc <= cyc - 2);
        checks++;
        if (bus_if.resp_valid !== exp_rv) begin
            errors++;
            $display("FAIL resp_valid cyc=%0d got=%b exp=%b", cyc, bus_if.resp_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (bus_if.resp_src !== 3'(q[0].src) || bus_if.resp_dir !== q[0].dir ||
                bus_if.resp_err !== (q[0].dir > 3'd4)) begin
                errors++;
                $display("FAIL resp_payload cyc=%0d got src=%0d dir=%0d err=%b exp src=%0d dir=%0d err=%b",
                         cyc, bus_if.resp_src, bus_if.resp_dir, bus_if.resp_err,
                         q[0].src, q[0].dir, (q[0].dir > 3'd4));
            end
            if (bus_if.resp_ready) begin
                r.src = int'(bus_if.resp_src);
                r.dir = bus_if.resp_dir;
                r.err = bus_if.resp_err;
                got.push_back(r);
                void'(q.pop_front());
            end
        end
        if (g >= 0) begin
            it.src  = g;
            it.dest = hold[g];
            it.dir  = stub_arm ? 3'b111 : route(hold[g]);
            it.cyc  = cyc;
            q.push_back(it);
            mptr    = g;
            want[g] = 1'b0;
            gq.push_back(g);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.resp_valid !== 1'b0 || bus_if.req_ready !== '0 || rt_dest_id !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got rv=%b rdy=%b rt=%h exp 0/0/0",
                     bus_if.resp_valid, bus_if.req_ready, rt_dest_id);
        end
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        q.delete();
        mptr = N - 1;
        want = '0;
    endtask

    task automatic test_reset();
        want = '1;
        for (int i = 0; i < N; i++) hold[i] = 8'(8'h10 + i);
        bus_if.req_valid = want;
        bus_if.req_dest  = '1;
        @(negedge clk);
        #1;
        checks++;
        if (bus_if.resp_src !== 3'd0 || bus_if.resp_dir !== 3'd0 || bus_if.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload got src=%0d dir=%0d err=%b exp 0/0/0",
                     bus_if.resp_src, bus_if.resp_dir, bus_if.resp_err);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_directions();
        logic [7:0] dests [5] = '{8'h87, 8'h08, 8'hF7, 8'h07, 8'h00};
        logic [2:0] dirs  [5] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4};
        got.delete();
        bus_if.resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            want[2] = 1'b1;
            hold[2] = dests[k];
            step();
        end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL dir_count got=%0d exp=5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got[k].src != 2 || got[k].dir !== dirs[k]) begin
                    errors++;
                    $display("FAIL dir_%0d got src=%0d dir=%0d exp src=2 dir=%0d",
                             k, got[k].src, got[k].dir, dirs[k]);
                end
            end
        end
    endtask

    task automatic test_rr_order();
        int exp_seq [7] = '{0, 1, 2, 3, 4, 0, 1};
        @(negedge clk);
        #2;
        do_reset();
        gq.delete();
        got.delete();
        bus_if.resp_ready = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 8'($urandom);
        for (int k = 0; k < 7; k++) begin
            want = '1;
            step();
        end
        want = '0;
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (k >= gq.size() || gq[k] != exp_seq[k]) begin
                errors++;
                $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, (k < gq.size()) ? gq[k] : -1, exp_seq[k]);
            end
            checks++;
            if (k >= got.size() || got[k].src != exp_seq[k]) begin
                errors++;
                $display("FAIL rr_resp_src_%0d got=%0d exp=%0d", k, (k < got.size()) ? got[k].src : -1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        gq.delete();
        got.delete();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) if (!want[i]) hold[i] = 8'($urandom);
            want = '1;
            bus_if.resp_ready = !(k >= 4 && k <= 6);
            step();
        end
        want = '0;
        bus_if.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (got.size() != gq.size()) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=%0d", got.size(), gq.size());
        end
        for (int k = 0; k < got.size() && k < gq.size(); k++) begin
            checks++;
            if (got[k].src != gq[k]) begin
                errors++;
                $display("FAIL bp_order_%0d got=%0d exp=%0d", k, got[k].src, gq[k]);
            end
        end
    endtask

    task automatic test_err();
        got.delete();
        bus_if.resp_ready = 1'b1;
        want[1] = 1'b1;
        hold[1] = 8'h87;
        stub_arm = 1'b1;
        step();
        stub_arm = 1'b0;
        want[3] = 1'b1;
        hold[3] = 8'h87;
        step();
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (got.size() != 2 || got[0].dir !== 3'd7 || got[0].err !== 1'b1 ||
            got[1].dir !== 3'd0 || got[1].err !== 1'b0) begin
            errors++;
            $display("FAIL err_flag got n=%0d first dir=%0d err=%b exp n=2 dir=7 err=1 then dir=0 err=0",
                     got.size(), (got.size() > 0) ? got[0].dir : 3'd0, (got.size() > 0) ? got[0].err : 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        bus_if.resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) if (!want[i]) hold[i] = 8'($urandom);
            want = '1;
            step();
        end
        checks++;
        if (bus_if.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_full got rv=%b exp=1", bus_if.resp_valid);
        end
        #2;
        do_reset();
        gq.delete();
        n0 = gq.size();
        want = '1;
        bus_if.resp_ready = 1'b1;
        step();
        checks++;
        if (gq.size() <= n0 || gq[n0] != 0) begin
            errors++;
            $display("FAIL first_grant_after_reset got=%0d exp=0", (gq.size() > n0) ? gq[n0] : -1);
        end
        want = '0;
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 24; k++) begin
            want = '0;
            if (k % 2 == 0) begin want[4] = 1'b1; hold[4] = 8'($urandom); end
            else            begin want[0] = 1'b1; hold[0] = 8'($urandom); end
            bus_if.resp_ready = ((k / 3) % 2 == 0);
            step();
        end
        want = '0;
        bus_if.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(99) < 45) begin
                    want[i] = 1'b1;
                    hold[i] = 8'($urandom);
                end
            end
            bus_if.resp_ready = ($urandom_range(99) < 70);
            step();
        end
        want = '0;
        bus_if.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
    endtask

    initial begin
        rst = 1'b1;
        stub_arm = 1'b0;
        bus_if.resp_ready = 1'b1;
        test_reset();
        test_directions();
        test_rr_order();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_alternate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d exp completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/rtable_lookup_arb.md
Name: rtable_lookup_arb

Overview:
- Shares the single-port, registered route table lookup (8-bit destination ID in, 3-bit direction out, 1-cycle latency) among the router's input ports (N, E, S, W, Local).
- Round-robin arbitrates per-port lookup requests and issues at most one lookup per cycle.
- Tracks the in-flight lookup and returns each direction, tagged with its source port, on one shared response channel with backpressure.
- Sits between the input-port buffers and the route table instance inside each mesh router.

Parameters:
- NPORTS, 5, number of requesting input ports.
- ID_W, 8, destination ID width; must equal the route table's ID width.
- DIR_W, 3, direction code width.
- SRC_W, 3, width of the source-port tag; equals $clog2(NPORTS).

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NPORTS  per-port lookup request.
- req_dest  in  NPORTS*ID_W  per-port destination ID; port i occupies bits [i*ID_W +: ID_W].
- req_ready  out  NPORTS  one-hot grant; a request is accepted in a cycle where req_valid[i] and req_ready[i] are both high.
- rt_dest_id  out  ID_W  drives the route table's dest_id input.
- rt_switch_port  in  DIR_W  route table output; valid in the cycle after rt_dest_id was sampled.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_src  out  SRC_W  index of the port that issued the request.
- resp_dir  out  DIR_W  direction code: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
- resp_err  out  1  high when resp_dir is greater than 4.

Behaviour:
Pipeline:
- S1 holds the in-flight lookup: s1_v, s1_src, s1_dest.
- S2 is the response register: resp_valid, resp_src, resp_dir, resp_err.
- adv2 = !resp_valid || resp_ready. When adv2 is high, S2 loads from S1 (resp_dir <= rt_switch_port); if s1_v=0, resp_valid goes low.
- adv1 = !s1_v || adv2. A new issue is allowed only when adv1 is high.
Rules:
- Issue:
  - When adv1 is high and any req_valid is set, grant exactly one port: req_ready one-hot and combinational from req_valid and the pointer.
  - rt_dest_id = granted req_dest; S1 loads {1, src, dest}.
  - When adv1 is high with no request, S1 clears.
- Stall: while adv1 is low, req_ready = 0 and rt_dest_id = s1_dest, so the route table re-samples the same ID and rt_switch_port stays valid.
- Idle (no request, S1 empty): rt_dest_id = 0.
- Latency: accept in cycle c gives resp_valid in cycle c+2 when there is no backpressure.
- Throughput: one lookup per cycle sustained; no bubble when S2 drains while S1 reloads.
- Ordering: responses leave in acceptance order; no response is dropped or duplicated.
Round-robin:
- ptr holds the last granted index.
- Priority order is ptr+1, ptr+2, ... modulo NPORTS, wrapping from NPORTS-1 to 0.
- ptr updates only on an accept.
- A port whose req_valid stays high is granted within NPORTS issue slots.
Requester obligation: req_dest must be held stable while req_valid is high and unaccepted. This is not checked.
Reset (async, effective immediately, including mid-operation):
- s1_v=0, resp_valid=0, resp_src=0, resp_dir=0, resp_err=0, ptr=NPORTS-1 (so port 0 wins first).
- req_ready=0 and rt_dest_id=0 while rst is high.
- In-flight lookups are discarded; requesters re-present them after reset.
Error:
- resp_err = (rt_switch_port > 4), registered alongside resp_dir.
- The response is still delivered; the block takes no other action.

Decomposition:
- Shared package rtable_pkg:
  - direction localparams DIR_LOCAL..DIR_WEST;
  - NPORTS, ID_W, DIR_W;
  - port-index constants P_LOCAL..P_WEST.
- Sub-module rr_arbiter (NPORTS): inputs req, ptr, en; outputs grant one-hot, grant_idx, any.
- The pipeline and pointer register stay in rtable_lookup_arb.

Test Plan:
Bench instantiates the route table configured for node (7,8) on a 16x16 mesh.
1. Port 2 requests dest 0x87, then dest 0x08:
   - resp at c+2 with src=2, dir=0 (LOCAL); then src=2, dir=2 (EAST);
   - dest 0xF7 gives NORTH, 0x07 gives SOUTH, 0x00 gives WEST.
2. All 5 ports hold req_valid, resp_ready=1:
   - grants in order 0,1,2,3,4,0,1, one per cycle;
   - resp_src follows the same sequence two cycles later.
3. Continuous requests with resp_ready low for cycles 4-6:
   - req_ready=0 and rt_dest_id held at s1_dest during the stall;
   - after release, every accepted request is answered exactly once, in order.
4. Bench drives rt_switch_port=3'b111 through a stub route table: resp_err=1 and resp_dir=7 on that response only.
5. rst pulsed high mid-stream with S1 and S2 full:
   - resp_valid drops with no clock edge;
   - the first grant after reset goes to port 0 when all ports request.
6. Port 4 alone then port 0 alone on alternating cycles, resp_ready toggling: no bubble when S2 drains and S1 reloads in the same cycle; the pointer wraps correctly from 4 to 0.
